// File: rtl/z8_processor_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_set (package)
//  Description : Opcode encoding, flag and instruction layouts and control
//                states shared by the z8 processor core and its benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_set;

    // Stack pointer value after reset: top of the 256-word data memory
    localparam logic [15:0] c_SP_RESET = 16'h00FF;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDD  = 8'h01,
        OP_MOV  = 8'h02,
        OP_LDM  = 8'h03,
        OP_STM  = 8'h04,
        OP_ADD  = 8'h05,
        OP_SUB  = 8'h06,
        OP_AND  = 8'h07,
        OP_OR   = 8'h08,
        OP_XOR  = 8'h09,
        OP_PSHR = 8'h0A,
        OP_PSHD = 8'h0B,
        OP_POP  = 8'h0C,
        OP_JMP  = 8'h0D,
        OP_JZ   = 8'h0E,
        OP_HALT = 8'hFF
    } opcode_t;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic negative;
        logic zero;
    } flags_t;

    // Opcode is kept as raw bits so undefined encodings can fall through as NOP
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] a;
        logic [15:0] b;
    } instr_t;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/z8_processor_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : z8_processor_core_if
//  Description : Internal bus between the control unit (master) and the
//                memory / register-file blocks (slaves).
//  Revision    : 1.0 - initial release
// ============================================================================
interface z8_processor_core_if;

    // Program fetch port
    logic [7:0]  prog_addr;
    logic [39:0] prog_data;

    // Data memory port (shared by LDM/STM and the stack)
    logic [7:0]  data_addr;
    logic        data_we;
    logic [15:0] data_wdata;
    logic [15:0] data_rdata;

    // Register file: two read ports, one write port
    logic [2:0]  rd_a_idx;
    logic [2:0]  rd_b_idx;
    logic [15:0] rd_a_data;
    logic [15:0] rd_b_data;
    logic        rf_we;
    logic [2:0]  rf_widx;
    logic [15:0] rf_wdata;

    modport master (
        output prog_addr, data_addr, data_we, data_wdata,
               rd_a_idx, rd_b_idx, rf_we, rf_widx, rf_wdata,
        input  prog_data, data_rdata, rd_a_data, rd_b_data
    );

    modport slave_mem (
        input  prog_addr, data_addr, data_we, data_wdata,
        output prog_data, data_rdata
    );

    modport slave_rf (
        input  rd_a_idx, rd_b_idx, rf_we, rf_widx, rf_wdata,
        output rd_a_data, rd_b_data
    );

endinterface
`default_nettype wire

// File: rtl/z8_processor_core_cu.sv
`default_nettype none
// ============================================================================
//  Module      : z8_processor_core_cu
//  Description : Control unit: FETCH/EXEC sequencer, pc, stack pointer,
//                flags and ALU. Drives all memory and register writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module z8_processor_core_cu (
    input  logic                 clk,
    input  logic                 rst,
    z8_processor_core_if.master  bus
);

    import instruction_set::*;

    state_t      r_state;
    instr_t      r_ir;
    logic [15:0] pc;
    logic [15:0] stack_ptr;
    logic        halted;
    flags_t      flags;

    logic        w_exec;
    logic [15:0] w_ra;
    logic [15:0] w_rb;
    logic [15:0] w_sp_inc;
    logic [15:0] w_sp_dec;
    logic [16:0] w_sum;
    logic [15:0] w_alu_res;
    flags_t      w_alu_flags;
    logic        w_alu_upd;

    // Writes are only allowed in a live EXEC cycle
    assign w_exec = (r_state == ST_EXEC) && !halted;
    assign w_ra   = bus.rd_a_data;
    assign w_rb   = bus.rd_b_data;

    assign bus.prog_addr = pc[7:0];
    assign bus.rd_a_idx  = r_ir.a[2:0];
    assign bus.rd_b_idx  = r_ir.b[2:0];

    // Stack pointer lives in 0x00..0xFF and wraps in both directions
    assign w_sp_inc = (stack_ptr + 16'd1) & 16'h00FF;
    assign w_sp_dec = (stack_ptr - 16'd1) & 16'h00FF;

    // ALU: result and next flags for arithmetic/logic opcodes
    always_comb begin
        w_sum       = 17'd0;
        w_alu_res   = 16'h0000;
        w_alu_flags = flags;
        w_alu_upd   = 1'b0;
        case (r_ir.opcode)
            OP_ADD: begin
                w_sum                = {1'b0, w_ra} + {1'b0, w_rb};
                w_alu_res            = w_sum[15:0];
                w_alu_flags.carry    = w_sum[16];
                w_alu_flags.overflow = (w_ra[15] == w_rb[15]) && (w_sum[15] != w_ra[15]);
                w_alu_upd            = 1'b1;
            end
            OP_SUB: begin
                // Bit 16 of the 17-bit difference is the borrow (Ra < Rb)
                w_sum                = {1'b0, w_ra} - {1'b0, w_rb};
                w_alu_res            = w_sum[15:0];
                w_alu_flags.carry    = w_sum[16];
                w_alu_flags.overflow = (w_ra[15] != w_rb[15]) && (w_sum[15] != w_ra[15]);
                w_alu_upd            = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (r_ir.opcode == OP_AND) begin
                    w_alu_res = w_ra & w_rb;
                end else if (r_ir.opcode == OP_OR) begin
                    w_alu_res = w_ra | w_rb;
                end else begin
                    w_alu_res = w_ra ^ w_rb;
                end
                w_alu_flags.carry    = 1'b0;
                w_alu_flags.overflow = 1'b0;
                w_alu_upd            = 1'b1;
            end
            default: ;
        endcase
        if (w_alu_upd) begin
            w_alu_flags.negative = w_alu_res[15];
            w_alu_flags.zero     = (w_alu_res == 16'h0000);
        end
    end

    // Data memory port: direct addressing for LDM/STM, SP-relative for stack
    always_comb begin
        bus.data_addr  = r_ir.b[7:0];
        bus.data_we    = 1'b0;
        bus.data_wdata = w_ra;
        case (r_ir.opcode)
            OP_STM:  bus.data_we = w_exec;
            OP_PSHR: begin
                bus.data_addr = stack_ptr[7:0];
                bus.data_we   = w_exec;
            end
            OP_PSHD: begin
                bus.data_addr  = stack_ptr[7:0];
                bus.data_wdata = r_ir.a;
                bus.data_we    = w_exec;
            end
            OP_POP:  bus.data_addr = w_sp_inc[7:0];
            default: ;
        endcase
    end

    // Register write-back source selection
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_widx  = r_ir.a[2:0];
        bus.rf_wdata = w_alu_res;
        case (r_ir.opcode)
            OP_LDD: begin
                bus.rf_we    = w_exec;
                bus.rf_wdata = r_ir.b;
            end
            OP_MOV: begin
                bus.rf_we    = w_exec;
                bus.rf_wdata = w_rb;
            end
            OP_LDM, OP_POP: begin
                bus.rf_we    = w_exec;
                bus.rf_wdata = bus.data_rdata;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: bus.rf_we = w_exec;
            default: ;
        endcase
    end

    // Sequencer: fetch then execute; everything freezes once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            pc        <= 16'h0000;
            stack_ptr <= c_SP_RESET;
            halted    <= 1'b0;
            flags     <= '0;
        end else if (!halted) begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= instr_t'(bus.prog_data);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH;
                    pc      <= pc + 16'd1;
                    if (w_alu_upd) begin
                        flags <= w_alu_flags;
                    end
                    case (r_ir.opcode)
                        OP_PSHR, OP_PSHD: stack_ptr <= w_sp_dec;
                        OP_POP:           stack_ptr <= w_sp_inc;
                        OP_JMP:           pc <= r_ir.a;
                        OP_JZ: begin
                            if (flags.zero) begin
                                pc <= r_ir.a;
                            end
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            pc     <= pc;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/z8_processor_core_mem.sv
`default_nettype none
// ============================================================================
//  Module      : z8_processor_core_mem
//  Description : Program memory (loaded by back-door, never reset) and data
//                memory (cleared by reset, one write port).
//  Revision    : 1.0 - initial release
// ============================================================================
module z8_processor_core_mem #(
    parameter int PROG_DEPTH = 256,
    parameter int DATA_DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    z8_processor_core_if.slave_mem  bus
);

    // Program image is written hierarchically from outside the core
    logic [39:0] prog_mem [PROG_DEPTH];
    logic [15:0] data_mem [DATA_DEPTH];

    assign bus.prog_data  = prog_mem[bus.prog_addr];
    assign bus.data_rdata = data_mem[bus.data_addr];

    // Data memory: whole array cleared on reset, single synchronous write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                data_mem[i] <= 16'h0000;
            end
        end else if (bus.data_we) begin
            data_mem[bus.data_addr] <= bus.data_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/z8_processor_core_rf.sv
`default_nettype none
// ============================================================================
//  Module      : z8_processor_core_rf
//  Description : General register file, two asynchronous read ports and one
//                synchronous write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module z8_processor_core_rf #(
    parameter int NUM_REGS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    z8_processor_core_if.slave_rf  bus
);

    logic [15:0] registers [NUM_REGS];

    assign bus.rd_a_data = registers[bus.rd_a_idx];
    assign bus.rd_b_data = registers[bus.rd_b_idx];

    // Register write port, all registers cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registers[i] <= 16'h0000;
            end
        end else if (bus.rf_we) begin
            registers[bus.rf_widx] <= bus.rf_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/z8_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : z8_processor_core
//  Description : 16-bit stack-capable processor core; ties the control unit
//                to its memories and register file over the internal bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module z8_processor_core #(
    parameter int PROG_DEPTH = 256,
    parameter int DATA_DEPTH = 256,
    parameter int NUM_REGS   = 8
) (
    input  logic clk,
    input  logic reset
);

    z8_processor_core_if bus ();

    z8_processor_core_mem #(
        .PROG_DEPTH (PROG_DEPTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) mem (
        .clk (clk),
        .rst (reset),
        .bus (bus)
    );

    z8_processor_core_rf #(
        .NUM_REGS (NUM_REGS)
    ) rf (
        .clk (clk),
        .rst (reset),
        .bus (bus)
    );

    z8_processor_core_cu cu (
        .clk (clk),
        .rst (reset),
        .bus (bus)
    );

endmodule
`default_nettype wire

// File: tb/tb_z8_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z8_processor_core
//  Description : Self-checking bench: programs are loaded into the core, a
//                reference interpreter predicts the final state, and a
//                monitor compares it when the core halts and again later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_z8_processor_core;

    import instruction_set::*;

    typedef struct packed {
        logic [7:0][15:0]   regs;
        logic [255:0][15:0] dmem;
        logic [15:0]        sp;
        flags_t             flags;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    exp_t        exp_q [$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          runs_done    = 0;
    string       cur_name     = "none";
    logic [39:0] prog [256];

    always #5 clk = ~clk;

    z8_processor_core #(
        .PROG_DEPTH (256),
        .DATA_DEPTH (256),
        .NUM_REGS   (8)
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    function automatic logic [39:0] ins(logic [7:0] op, logic [15:0] a, logic [15:0] b);
        return {op, a, b};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s [%s]: got %h expected %h", nm, cur_name, act, exp);
        end
    endtask

    // Reference interpreter working directly from the instruction rules
    function automatic exp_t model_run();
        exp_t        e;
        logic [15:0] r [8];
        logic [15:0] m [256];
        flags_t      f;
        int          pc, sp, s, sa, sb;
        logic [39:0] w;
        logic [7:0]  op;
        logic [15:0] a, b, ra, rb, res;
        bit          halt, upd;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        for (int i = 0; i < 256; i++) m[i] = 16'h0;
        f = '0; pc = 0; sp = 255; halt = 0;
        for (int steps = 0; steps < 20000 && !halt; steps++) begin
            w  = prog[pc % 256];
            op = w[39:32]; a = w[31:16]; b = w[15:0];
            ra = r[a[2:0]]; rb = r[b[2:0]];
            sa = $signed(ra); sb = $signed(rb);
            upd = 0; res = 16'h0;
            pc = (pc + 1) % 65536;
            case (op)
                8'h01: r[a[2:0]] = b;
                8'h02: r[a[2:0]] = rb;
                8'h03: r[a[2:0]] = m[b[7:0]];
                8'h04: m[b[7:0]] = ra;
                8'h05: begin
                    s = int'(ra) + int'(rb); res = s[15:0]; upd = 1;
                    f.carry = (s > 65535);
                    f.overflow = ((sa + sb) > 32767) || ((sa + sb) < -32768);
                end
                8'h06: begin
                    s = int'(ra) - int'(rb); res = s[15:0]; upd = 1;
                    f.carry = (ra < rb);
                    f.overflow = ((sa - sb) > 32767) || ((sa - sb) < -32768);
                end
                8'h07: begin res = ra & rb; upd = 1; f.carry = 0; f.overflow = 0; end
                8'h08: begin res = ra | rb; upd = 1; f.carry = 0; f.overflow = 0; end
                8'h09: begin res = ra ^ rb; upd = 1; f.carry = 0; f.overflow = 0; end
                8'h0A: begin m[sp] = ra; sp = (sp + 255) % 256; end
                8'h0B: begin m[sp] = a;  sp = (sp + 255) % 256; end
                8'h0C: begin sp = (sp + 1) % 256; r[a[2:0]] = m[sp]; end
                8'h0D: pc = int'(a);
                8'h0E: if (f.zero) pc = int'(a);
                8'hFF: halt = 1;
                default: ;
            endcase
            if (upd) begin
                r[a[2:0]] = res;
                f.negative = res[15];
                f.zero = (res == 16'h0);
            end
        end
        for (int i = 0; i < 8; i++) e.regs[i] = r[i];
        for (int i = 0; i < 256; i++) e.dmem[i] = m[i];
        e.sp = sp[15:0];
        e.flags = f;
        return e;
    endfunction

    task automatic compare_state(exp_t e, string phase);
        int idx;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s R%0d", phase, i), {16'h0, dut.rf.registers[i]}, {16'h0, e.regs[i]});
        end
        check({phase, " sp"}, {16'h0, dut.cu.stack_ptr}, {16'h0, e.sp});
        check({phase, " flags(ov,c,n,z)"}, {28'h0, dut.cu.flags}, {28'h0, e.flags});
        idx = 0;
        for (int i = 255; i >= 0; i--) begin
            if (dut.mem.data_mem[i] !== e.dmem[i]) idx = i;
        end
        check($sformatf("%s dmem[%0d]", phase, idx), {16'h0, dut.mem.data_mem[idx]}, {16'h0, e.dmem[idx]});
    endtask

    // Monitor: waits for the core to halt, compares, then checks the freeze
    initial begin : monitor
        exp_t e;
        int   c;
        forever begin
            while (exp_q.size() == 0) @(negedge clk);
            c = 0;
            while (dut.cu.halted !== 1'b1 && c < 20000) begin
                @(negedge clk);
                c++;
            end
            e = exp_q.pop_front();
            if (dut.cu.halted !== 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL halt_timeout [%s]: got halted=%b expected 1", cur_name, dut.cu.halted);
            end else begin
                compare_state(e, "halt");
                repeat (50) @(negedge clk);
                check("frozen halted", {31'h0, dut.cu.halted}, 32'h1);
                compare_state(e, "frozen");
            end
            runs_done++;
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = ins(OP_HALT, 16'h0, 16'h0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.mem.prog_mem[i] = prog[i];
    endtask

    // Reset, load, predict, release, and wait for the monitor to finish
    task automatic run_prog(string name);
        int target;
        @(negedge clk);
        reset = 1'b1;
        cur_name = name;
        load_prog();
        exp_q.push_back(model_run());
        target = runs_done + 1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40000 && runs_done < target; c++) @(negedge clk);
        if (runs_done < target) begin
            tests_run++;
            tests_failed++;
            $display("FAIL run_timeout [%s]: got runs_done=%0d expected %0d", name, runs_done, target);
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $fatal(1, "bench stalled");
        end
    endtask

    task automatic gen_random();
        int          len, kind, tgt;
        logic [15:0] a, b;
        clear_prog();
        len = $urandom_range(40, 12);
        for (int i = 0; i < len - 1; i++) begin
            kind = $urandom_range(15, 0);
            a = 16'($urandom);
            b = 16'($urandom);
            tgt = $urandom_range(len - 1, i + 1);
            case (kind)
                0, 1, 2: prog[i] = ins(OP_LDD, a, b);
                3:  prog[i] = ins(OP_MOV, a, b);
                4:  prog[i] = ins(OP_LDM, a, b);
                5:  prog[i] = ins(OP_STM, a, b);
                6:  prog[i] = ins(OP_ADD, a, b);
                7:  prog[i] = ins(OP_SUB, a, b);
                8:  prog[i] = ins(OP_AND, a, b);
                9:  prog[i] = ins(OP_OR, a, b);
                10: prog[i] = ins(OP_XOR, a, b);
                11: prog[i] = ins(OP_PSHR, a, b);
                12: prog[i] = ins(OP_PSHD, a, b);
                13: prog[i] = ins(OP_POP, a, b);
                14: prog[i] = ins((a[0] ? OP_JZ : OP_JMP), 16'(tgt), b);
                default: prog[i] = ins(8'h20 + 8'(a[3:0]), a, b);
            endcase
        end
    endtask

    initial begin : stimulus
        int          idx;
        logic [39:0] saved [256];

        repeat (3) @(negedge clk);
        cur_name = "reset";
        check("reset pc", {16'h0, dut.cu.pc}, 32'h0);
        check("reset sp", {16'h0, dut.cu.stack_ptr}, 32'h00FF);
        check("reset halted", {31'h0, dut.cu.halted}, 32'h0);
        check("reset flags", {28'h0, dut.cu.flags}, 32'h0);
        check("reset R0", {16'h0, dut.rf.registers[0]}, 32'h0);

        // Stack program
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd0, 16'h0001);
        prog[1] = ins(OP_PSHR, 16'd0, 16'h0);
        prog[2] = ins(OP_PSHD, 16'h0002, 16'h0);
        prog[3] = ins(OP_POP, 16'd1, 16'h0);
        run_prog("stack");

        // ADD signed overflow, then carry-out to zero
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd0, 16'h7FFF);
        prog[1] = ins(OP_LDD, 16'd1, 16'h0001);
        prog[2] = ins(OP_ADD, 16'd0, 16'd1);
        run_prog("add_ovf");
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd0, 16'hFFFF);
        prog[1] = ins(OP_LDD, 16'd1, 16'h0001);
        prog[2] = ins(OP_ADD, 16'd0, 16'd1);
        run_prog("add_carry");

        // SUB borrow, JZ not taken, XOR to zero, JZ taken
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd0, 16'h0003);
        prog[1] = ins(OP_LDD, 16'd1, 16'h0005);
        prog[2] = ins(OP_SUB, 16'd0, 16'd1);
        prog[3] = ins(OP_JZ, 16'd7, 16'h0);
        prog[4] = ins(OP_LDD, 16'd4, 16'hAAAA);
        prog[5] = ins(OP_XOR, 16'd0, 16'd0);
        prog[6] = ins(OP_JZ, 16'd8, 16'h0);
        prog[7] = ins(OP_LDD, 16'd5, 16'hBBBB);
        run_prog("sub_jz");

        // Store / load round trip
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd2, 16'h1234);
        prog[1] = ins(OP_STM, 16'd2, 16'h0010);
        prog[2] = ins(OP_LDM, 16'd3, 16'h0010);
        run_prog("stm_ldm");

        // 256 pushes wrap SP back to 0xFF
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd1, 16'h0100);
        prog[1] = ins(OP_LDD, 16'd2, 16'h0001);
        prog[2] = ins(OP_LDD, 16'd0, 16'h0000);
        prog[3] = ins(OP_ADD, 16'd0, 16'd2);
        prog[4] = ins(OP_PSHR, 16'd0, 16'h0);
        prog[5] = ins(OP_SUB, 16'd1, 16'd2);
        prog[6] = ins(OP_JZ, 16'd8, 16'h0);
        prog[7] = ins(OP_JMP, 16'd3, 16'h0);
        run_prog("sp_wrap");

        // Reset asserted during EXEC of the second PSHD
        clear_prog();
        prog[0] = ins(OP_LDD, 16'd0, 16'h0005);
        prog[1] = ins(OP_PSHD, 16'h0077, 16'h0);
        prog[2] = ins(OP_PSHD, 16'h0088, 16'h0);
        prog[3] = ins(OP_PSHR, 16'd0, 16'h0);
        prog[4] = ins(OP_POP, 16'd1, 16'h0);
        for (int i = 0; i < 256; i++) saved[i] = prog[i];
        cur_name = "reset_mid";
        @(negedge clk);
        reset = 1'b1;
        load_prog();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (dut.cu.r_state == ST_EXEC && dut.cu.r_ir.opcode == OP_PSHD && dut.cu.pc == 16'd2) break;
            @(negedge clk);
        end
        check("pre_reset in PSHD exec", {31'h0, dut.cu.r_state == ST_EXEC && dut.cu.pc == 16'd2}, 32'h1);
        check("pre_reset dmem[FF]", {16'h0, dut.mem.data_mem[255]}, 32'h0077);
        reset = 1'b1;
        #1;
        check("mid_reset sp", {16'h0, dut.cu.stack_ptr}, 32'h00FF);
        check("mid_reset pc", {16'h0, dut.cu.pc}, 32'h0);
        check("mid_reset R0", {16'h0, dut.rf.registers[0]}, 32'h0);
        idx = 0;
        for (int i = 255; i >= 0; i--) if (dut.mem.data_mem[i] !== 16'h0) idx = i;
        check($sformatf("mid_reset dmem[%0d]", idx), {16'h0, dut.mem.data_mem[idx]}, 32'h0);
        idx = 0;
        for (int i = 255; i >= 0; i--) if (dut.mem.prog_mem[i] !== saved[i]) idx = i;
        check($sformatf("mid_reset prog_mem[%0d] low", idx), dut.mem.prog_mem[idx][31:0], saved[idx][31:0]);
        check($sformatf("mid_reset prog_mem[%0d] op", idx), {24'h0, dut.mem.prog_mem[idx][39:32]}, {24'h0, saved[idx][39:32]});
        exp_q.push_back(model_run());
        idx = runs_done + 1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2000 && runs_done < idx; c++) @(negedge clk);
        check("rerun completed", {31'h0, runs_done >= idx}, 32'h1);

        // Randomized programs
        for (int n = 0; n < 20; n++) begin
            gen_random();
            run_prog($sformatf("random%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #900000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog [%s]: got timeout expected completion", cur_name);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
